// File: rtl/ahbextmemctrl_pkg.sv
// ahbextmemctrl_pkg: shared types and helpers for the external-memory AHB subordinate.
package ahbextmemctrl_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} ahbextstatetype;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // A transfer is legal when it fits in one bus beat and is naturally aligned.
    // The memory-map checker calls this too, so it only looks at the low address bits.
    function automatic logic legalTransfer(input logic [2:0] size,
                                           input logic [2:0] addrLow,
                                           input logic [2:0] maxSize);
        logic [7:0] mask;
        mask = (8'd1 << size) - 8'd1;
        return (size <= maxSize) && (({5'b0, addrLow} & mask) == 8'd0);
    endfunction

endpackage

// File: rtl/ahbextmemctrl_if.sv
// ahbextmemctrl_if: AHB-Lite signals between the SoC and the external-memory subordinate.
interface ahbextmemctrl_if #(
    parameter int AHBW    = 64,
    parameter int PA_BITS = 34
);
    logic                 HSELEXT;
    logic [PA_BITS-1:0]   HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [2:0]           HSIZE;
    logic [AHBW-1:0]      HWDATA;
    logic [AHBW/8-1:0]    HWSTRB;
    logic                 HREADY;
    logic [AHBW-1:0]      HRDATAEXT;
    logic                 HREADYEXT;
    logic                 HRESPEXT;

    modport slave (
        input  HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
        output HRDATAEXT, HREADYEXT, HRESPEXT
    );

    modport master (
        output HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
        input  HRDATAEXT, HREADYEXT, HRESPEXT
    );
endinterface

// File: rtl/ahbextmemctrl_flop.sv
// Resettable flop primitives used for the controller's state and datapath registers.
module flopr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    // Plain register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) o_q <= '0;
        else       o_q <= i_d;
    end
endmodule

module flopenr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    // Register that only loads when enabled; reset has priority over the enable.
    always_ff @(posedge clk) begin
        if (reset)     o_q <= '0;
        else if (i_en) o_q <= i_d;
    end
endmodule

// File: rtl/ahbextmemctrl.sv
// ahbextmemctrl: AHB-Lite subordinate bridging the external-memory port to a
// request/acknowledge word-wide backend, with size/alignment errors and a stall timeout.
module ahbextmemctrl
    import ahbextmemctrl_pkg::*;
#(
    parameter int AHBW    = 64,
    parameter int PA_BITS = 34,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    ahbextmemctrl_if.slave      ahb,
    output logic                MemReq,
    output logic                MemWrite,
    output logic [PA_BITS-1:0]  MemAdr,
    output logic [AHBW-1:0]     MemWData,
    output logic [AHBW/8-1:0]   MemWStrb,
    input  logic [AHBW-1:0]     MemRData,
    input  logic                MemAck
);
    localparam int             OFFB    = $clog2(AHBW/8);
    localparam logic [2:0]     MAXSIZE = 3'(OFFB);
    localparam int             CW      = $clog2(TIMEOUT+1);
    localparam logic [CW-1:0]  TMAX    = CW'(TIMEOUT);

    ahbextstatetype      r_state, w_nextState;
    logic [1:0]          r_stateBits;
    logic                w_accept, w_legal, w_canAccept, w_takeNew, w_startXfer;
    logic                w_inAccess, w_timedOut, w_cntEn;
    logic [CW-1:0]       r_waitCnt, w_cntD;
    logic [PA_BITS-1:0]  w_alignedAdr, r_adr;
    logic                r_write;

    assign r_state      = ahbextstatetype'(r_stateBits);
    assign w_inAccess   = (r_state == ACCESS);
    assign w_accept     = ahb.HSELEXT & ahb.HREADY &
                          ((ahb.HTRANS == HTRANS_NONSEQ) | (ahb.HTRANS == HTRANS_SEQ));
    assign w_legal      = legalTransfer(ahb.HSIZE, ahb.HADDR[2:0], MAXSIZE);
    assign w_canAccept  = (r_state == IDLE) | (r_state == ERR2) | (w_inAccess & MemAck);
    assign w_takeNew    = w_accept & w_canAccept;
    assign w_startXfer  = w_takeNew & w_legal;
    assign w_timedOut   = w_inAccess & ~MemAck & (r_waitCnt == TMAX);
    assign w_alignedAdr = {ahb.HADDR[PA_BITS-1:OFFB], OFFB'(0)};

    flopr #(.WIDTH(2)) stateReg (
        .clk(clk), .reset(reset), .i_d(w_nextState), .o_q(r_stateBits)
    );

    flopenr #(.WIDTH(PA_BITS+1)) ctrlReg (
        .clk(clk), .reset(reset), .i_en(w_takeNew),
        .i_d({w_alignedAdr, ahb.HWRITE}), .o_q({r_adr, r_write})
    );

    // The wait counter restarts at each new transfer and creeps up while the backend stalls,
    // holding at TIMEOUT rather than wrapping.
    assign w_cntEn = w_startXfer | (w_inAccess & ~MemAck & (r_waitCnt != TMAX));
    assign w_cntD  = w_startXfer ? '0 : r_waitCnt + CW'(1);

    flopenr #(.WIDTH(CW)) waitReg (
        .clk(clk), .reset(reset), .i_en(w_cntEn), .i_d(w_cntD), .o_q(r_waitCnt)
    );

    // Next-state and bus/backend response decode from the current state and handshake inputs.
    always_comb begin
        w_nextState   = r_state;
        ahb.HREADYEXT = 1'b0;
        ahb.HRESPEXT  = 1'b0;
        ahb.HRDATAEXT = '0;
        MemReq        = 1'b0;
        MemWStrb      = '0;
        case (r_state)
            IDLE: begin
                ahb.HREADYEXT = 1'b1;
                if (w_accept) w_nextState = w_legal ? ACCESS : ERR1;
            end
            ACCESS: begin
                MemReq = 1'b1;
                if (r_write) MemWStrb = ahb.HWSTRB;
                if (MemAck) begin
                    ahb.HREADYEXT = 1'b1;
                    if (!r_write) ahb.HRDATAEXT = MemRData;
                    if (w_accept) w_nextState = w_legal ? ACCESS : ERR1;
                    else          w_nextState = IDLE;
                end else if (w_timedOut) begin
                    w_nextState = ERR1;
                end
            end
            ERR1: begin
                ahb.HRESPEXT = 1'b1;
                w_nextState  = ERR2;
            end
            ERR2: begin
                ahb.HREADYEXT = 1'b1;
                ahb.HRESPEXT  = 1'b1;
                if (w_accept) w_nextState = w_legal ? ACCESS : ERR1;
                else          w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign MemWrite = r_write;
    assign MemAdr   = r_adr;
    assign MemWData = ahb.HWDATA;

endmodule
